// File: rtl/stage_ex_mdu_if.sv
// stage_ex_mdu_if: decode-to-execute inputs and execute-stage outputs
interface stage_ex_mdu_if #(
  parameter int WIDTH    = 32,
  parameter int OP_W     = 5,
  parameter int RF_SRC_W = 2,
  parameter int BRANCH_W = 3
);
  logic                id_valid;
  logic [WIDTH-1:0]    id_pc;
  logic [OP_W-1:0]     id_op;
  logic [WIDTH-1:0]    id_opa;
  logic [WIDTH-1:0]    id_opb;
  logic                id_memWE;
  logic [WIDTH-1:0]    id_memData;
  logic                id_rfWE;
  logic [4:0]          id_rfDst;
  logic [RF_SRC_W-1:0] id_rfSrc;
  logic [BRANCH_W-1:0] id_branchType;
  logic [WIDTH-1:0]    id_branchDst;
  logic                ex_stall;
  logic                ex_valid;
  logic [WIDTH-1:0]    ex_pc;
  logic [WIDTH-1:0]    ex_opResult;
  logic [WIDTH-1:0]    ex_memData;
  logic [WIDTH-1:0]    ex_branchDst;
  logic                ex_memWE;
  logic                ex_rfWE;
  logic [4:0]          ex_rfDst;
  logic [RF_SRC_W-1:0] ex_rfSrc;
  logic                ex_branchPermit;
  logic [WIDTH-1:0]    ex_hi;
  logic [WIDTH-1:0]    ex_lo;
  modport master (
    output id_valid, id_pc, id_op, id_opa, id_opb, id_memWE, id_memData,
           id_rfWE, id_rfDst, id_rfSrc, id_branchType, id_branchDst,
    input  ex_stall, ex_valid, ex_pc, ex_opResult, ex_memData, ex_branchDst,
           ex_memWE, ex_rfWE, ex_rfDst, ex_rfSrc, ex_branchPermit, ex_hi, ex_lo
  );
  modport slave (
    input  id_valid, id_pc, id_op, id_opa, id_opb, id_memWE, id_memData,
           id_rfWE, id_rfDst, id_rfSrc, id_branchType, id_branchDst,
    output ex_stall, ex_valid, ex_pc, ex_opResult, ex_memData, ex_branchDst,
           ex_memWE, ex_rfWE, ex_rfDst, ex_rfSrc, ex_branchPermit, ex_hi, ex_lo
  );
endinterface

// File: rtl/stage_ex_mdu.sv
// stage_ex_mdu: ID/EX register, ALU, branch evaluation and iterative multiply/divide with HI/LO
module stage_ex_mdu #(
  parameter int WIDTH      = 32,
  parameter int OP_W       = 5,
  parameter int RF_SRC_W   = 2,
  parameter int BRANCH_W   = 3,
  parameter int ENABLE_MDU = 1
) (
  input logic           clk,
  input logic           rst,
  stage_ex_mdu_if.slave bus
);
  localparam int SA_W  = $clog2(WIDTH);
  localparam int CNT_W = SA_W + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                valid_r, mem_we_r, rf_we_r;
  logic [WIDTH-1:0]    pc_r, opa_r, opb_r, mem_data_r, branch_dst_r;
  logic [OP_W-1:0]     op_r;
  logic [4:0]          rf_dst_r;
  logic [RF_SRC_W-1:0] rf_src_r;
  logic [BRANCH_W-1:0] branch_type_r;
  logic [WIDTH-1:0]    hi, lo, acc_hi, acc_lo, m;
  logic                is_div, neg_q, neg_r;
  logic                stall, start, sgn, div_op, a_neg, b_neg;
  logic [WIDTH-1:0]    a_mag, b_mag, res, diff, nxt_hi, nxt_lo, fin_hi, fin_lo;
  logic [WIDTH:0]      sum, t;
  logic [2*WIDTH-1:0]  prod_neg;
  logic [SA_W-1:0]     sa;
  logic                ge, zero;
  assign stall  = state == RUN;
  assign start  = (ENABLE_MDU != 0) && !stall && bus.id_valid &&
                  bus.id_op >= OP_W'(11) && bus.id_op <= OP_W'(14);
  assign sgn    = bus.id_op == OP_W'(11) || bus.id_op == OP_W'(13);
  assign div_op = bus.id_op == OP_W'(13) || bus.id_op == OP_W'(14);
  assign a_neg  = sgn & bus.id_opa[WIDTH-1];
  assign b_neg  = sgn & bus.id_opb[WIDTH-1];
  assign a_mag  = a_neg ? -bus.id_opa : bus.id_opa;
  assign b_mag  = b_neg ? -bus.id_opb : bus.id_opb;
  // One radix-2 step: shift-add multiply into {acc_hi,acc_lo}, or restoring divide with acc_hi as remainder
  assign sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
  assign t        = {acc_hi, acc_lo[WIDTH-1]};
  assign ge       = t >= {1'b0, m};
  assign diff     = t[WIDTH-1:0] - m;
  assign nxt_hi   = is_div ? (ge ? diff : t[WIDTH-1:0]) : sum[WIDTH:1];
  assign nxt_lo   = is_div ? {acc_lo[WIDTH-2:0], ge} : {sum[0], acc_lo[WIDTH-1:1]};
  assign prod_neg = -{nxt_hi, nxt_lo};
  assign fin_hi   = is_div ? (neg_r ? -nxt_hi : nxt_hi) : (neg_q ? prod_neg[2*WIDTH-1:WIDTH] : nxt_hi);
  assign fin_lo   = is_div ? (neg_q ? -nxt_lo : nxt_lo) : (neg_q ? prod_neg[WIDTH-1:0] : nxt_lo);
  // ID/EX register: loads every unstalled edge, write enables cleared for bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r       <= 1'b0;
      pc_r          <= '0;
      op_r          <= '0;
      opa_r         <= '0;
      opb_r         <= '0;
      mem_we_r      <= 1'b0;
      mem_data_r    <= '0;
      rf_we_r       <= 1'b0;
      rf_dst_r      <= '0;
      rf_src_r      <= '0;
      branch_type_r <= '0;
      branch_dst_r  <= '0;
    end else if (!stall) begin
      valid_r       <= bus.id_valid;
      pc_r          <= bus.id_pc;
      op_r          <= bus.id_op;
      opa_r         <= bus.id_opa;
      opb_r         <= bus.id_opb;
      mem_we_r      <= bus.id_valid & bus.id_memWE;
      mem_data_r    <= bus.id_memData;
      rf_we_r       <= bus.id_valid & bus.id_rfWE;
      rf_dst_r      <= bus.id_rfDst;
      rf_src_r      <= bus.id_rfSrc;
      branch_type_r <= bus.id_branchType;
      branch_dst_r  <= bus.id_branchDst;
    end
  end
  // MDU FSM: capture magnitudes on issue, iterate WIDTH times, sign-fix into HI/LO on the last step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state  <= RUN;
        cnt    <= CNT_W'(WIDTH - 1);
        acc_hi <= '0;
        acc_lo <= div_op ? a_mag : b_mag;
        m      <= div_op ? b_mag : a_mag;
        is_div <= div_op;
        neg_q  <= (a_neg ^ b_neg) & (!div_op || |bus.id_opb);
        neg_r  <= a_neg;
      end
    end else begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        hi    <= fin_hi;
        lo    <= fin_lo;
        state <= IDLE;
      end
    end
  end
  // ALU on registered operands; MDU issue ops and unknown codes give 0
  always_comb begin
    sa  = opa_r[SA_W-1:0];
    res = '0;
    case (int'(op_r))
      0:  res = opa_r + opb_r;
      1:  res = opa_r - opb_r;
      2:  res = opa_r & opb_r;
      3:  res = opa_r | opb_r;
      4:  res = opb_r << sa;
      5:  res = opb_r >> sa;
      6:  res = $unsigned($signed(opb_r) >>> sa);
      7:  res = opa_r ^ opb_r;
      8:  res = ~(opa_r | opb_r);
      9:  res = {{(WIDTH-1){1'b0}}, $signed(opa_r) < $signed(opb_r)};
      10: res = {{(WIDTH-1){1'b0}}, opa_r < opb_r};
      15: res = hi;
      16: res = lo;
      default: res = '0;
    endcase
  end
  assign zero                = ~|res;
  assign bus.ex_stall        = stall;
  assign bus.ex_valid        = valid_r & ~stall;
  assign bus.ex_pc           = pc_r;
  assign bus.ex_opResult     = res;
  assign bus.ex_memData      = mem_data_r;
  assign bus.ex_branchDst    = branch_dst_r;
  assign bus.ex_memWE        = mem_we_r & bus.ex_valid;
  assign bus.ex_rfWE         = rf_we_r & bus.ex_valid;
  assign bus.ex_rfDst        = rf_dst_r;
  assign bus.ex_rfSrc        = rf_src_r;
  assign bus.ex_hi           = hi;
  assign bus.ex_lo           = lo;
  assign bus.ex_branchPermit = bus.ex_valid &
    (branch_type_r == BRANCH_W'(1) ? zero :
     branch_type_r == BRANCH_W'(2) ? ~zero :
     branch_type_r == BRANCH_W'(3) ? res[WIDTH-1] : 1'b0);
endmodule

// File: tb/tb_stage_ex_mdu.sv
// tb_stage_ex_mdu: directed vectors for the execute stage with hand-computed results
module tb_stage_ex_mdu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  stage_ex_mdu_if bus();
  stage_ex_mdu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] bt);
    bus.id_valid      = v;
    bus.id_op         = op;
    bus.id_opa        = a;
    bus.id_opb        = b;
    bus.id_branchType = bt;
  endtask
  task automatic mdu(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int k;
    drive(1'b1, op, a, b, 3'd0);
    tick;
    k = 0;
    while (bus.ex_stall && k < 100) begin
      k++;
      tick;
    end
    chk({tag, "_cycles"}, 32'(k), 32'd32);
    chk({tag, "_hi"}, bus.ex_hi, exp_hi);
    chk({tag, "_lo"}, bus.ex_lo, exp_lo);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 3'd0);
    tick;
  endtask
  initial begin
    bus.id_pc = 32'h100; bus.id_memWE = 1'b0; bus.id_memData = '0; bus.id_rfWE = 1'b1;
    bus.id_rfDst = 5'd3; bus.id_rfSrc = 2'd1; bus.id_branchDst = 32'h200;
    drive(1'b1, 5'd0, 32'd1, 32'd2, 3'd1);
    repeat (3) tick;
    chk("rst_stall", 32'(bus.ex_stall), 32'd0);
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_result", bus.ex_opResult, 32'd0);
    chk("rst_hi", bus.ex_hi, 32'd0);
    rst = 1'b1;
    drive(1'b1, 5'd0, 32'd7, 32'd8, 3'd0); tick;
    chk("add", bus.ex_opResult, 32'd15);
    chk("add_valid", 32'(bus.ex_valid), 32'd1);
    chk("add_pc", bus.ex_pc, 32'h100);
    drive(1'b1, 5'd6, 32'd4, 32'h80000000, 3'd0); tick;
    chk("sra", bus.ex_opResult, 32'hF8000000);
    drive(1'b1, 5'd4, 32'd4, 32'd1, 3'd0); tick;
    chk("sll", bus.ex_opResult, 32'd16);
    drive(1'b1, 5'd9, 32'hFFFFFFFF, 32'd1, 3'd0); tick;
    chk("slt", bus.ex_opResult, 32'd1);
    drive(1'b1, 5'd10, 32'hFFFFFFFF, 32'd1, 3'd0); tick;
    chk("sltu", bus.ex_opResult, 32'd0);
    drive(1'b1, 5'd8, 32'd0, 32'd0, 3'd0); tick;
    chk("nor", bus.ex_opResult, 32'hFFFFFFFF);
    drive(1'b0, 5'd0, 32'd1, 32'd2, 3'd0); tick;
    chk("bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("bubble_rfwe", 32'(bus.ex_rfWE), 32'd0);
    drive(1'b1, 5'd1, 32'd5, 32'd5, 3'd1); tick;
    chk("beq_taken", 32'(bus.ex_branchPermit), 32'd1);
    drive(1'b0, 5'd1, 32'd5, 32'd5, 3'd1); tick;
    chk("beq_bubble", 32'(bus.ex_branchPermit), 32'd0);
    drive(1'b1, 5'd1, 32'd5, 32'd5, 3'd2); tick;
    chk("bne_not", 32'(bus.ex_branchPermit), 32'd0);
    drive(1'b1, 5'd1, 32'd1, 32'd2, 3'd3); tick;
    chk("bltz_taken", 32'(bus.ex_branchPermit), 32'd1);
    bus.id_rfDst = 5'd5; bus.id_memData = 32'hAAAA; bus.id_memWE = 1'b1; bus.id_rfWE = 1'b1;
    drive(1'b1, 5'd11, 32'hFFFFFFFD, 32'd5, 3'd0); tick;
    chk("mult_stall", 32'(bus.ex_stall), 32'd1);
    bus.id_rfDst = 5'd9; bus.id_memData = 32'h5555;
    drive(1'b1, 5'd16, 32'd0, 32'd0, 3'd0);
    n = 0;
    while (bus.ex_stall && n < 100) begin
      n++;
      if (n == 16) begin
        chk("hold_rfdst", 32'(bus.ex_rfDst), 32'd5);
        chk("hold_memdata", bus.ex_memData, 32'hAAAA);
        chk("hold_memwe", 32'(bus.ex_memWE), 32'd0);
        chk("hold_rfwe", 32'(bus.ex_rfWE), 32'd0);
        chk("hold_valid", 32'(bus.ex_valid), 32'd0);
      end
      tick;
    end
    chk("mult_cycles", 32'(n), 32'd32);
    chk("mult_valid_after", 32'(bus.ex_valid), 32'd1);
    chk("mult_rfdst_after", 32'(bus.ex_rfDst), 32'd5);
    chk("mult_lo", bus.ex_lo, 32'hFFFFFFF1);
    chk("mult_hi", bus.ex_hi, 32'hFFFFFFFF);
    tick;
    chk("mflo", bus.ex_opResult, 32'hFFFFFFF1);
    chk("mflo_rfdst", 32'(bus.ex_rfDst), 32'd9);
    bus.id_memWE = 1'b0;
    drive(1'b1, 5'd15, 32'd0, 32'd0, 3'd0); tick;
    chk("mfhi", bus.ex_opResult, 32'hFFFFFFFF);
    mdu("div_neg", 5'd13, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    mdu("divu_zero", 5'd14, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
    mdu("div_min", 5'd13, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    mdu("multu", 5'd12, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
    drive(1'b1, 5'd11, 32'd7, 32'd6, 3'd0); tick;
    repeat (10) tick;
    rst = 1'b0;
    #1;
    chk("abort_stall", 32'(bus.ex_stall), 32'd0);
    chk("abort_valid", 32'(bus.ex_valid), 32'd0);
    chk("abort_hi", bus.ex_hi, 32'd0);
    chk("abort_lo", bus.ex_lo, 32'd0);
    tick;
    rst = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_ex_mdu.md
Name: stage_ex_mdu

Overview:
Parametrised execute stage for the pipelined MIPS core. It contains the ID/EX pipeline register, a single-cycle ALU with an extended op set, and branch evaluation. It also contains an iterative multiply/divide unit (MDU) with HI/LO registers. While the MDU is busy, the block stalls upstream and emits bubbles downstream. It sits between decode and memory stages; `ex_*` outputs feed the MEM stage and the PC-select logic.

Parameters:
- WIDTH, 32, datapath width; power of two, ≥8.
- OP_W, 5, ALU op field width.
- RF_SRC_W, 2, register-file write-source select width (passed through).
- BRANCH_W, 3, branch type field width.
- ENABLE_MDU, 1, 0 = ops 11–16 produce 0, never stall, no HI/LO.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  WIDTH  instruction PC (debug, passed through as ex_pc).
- id_op  in  OP_W  operation code.
- id_opa, id_opb  in  WIDTH  operands.
- id_memWE  in  1;  id_memData  in  WIDTH.
- id_rfWE  in  1;  id_rfDst  in  5;  id_rfSrc  in  RF_SRC_W.
- id_branchType  in  BRANCH_W;  id_branchDst  in  WIDTH.
- ex_stall  out  1  hold decode/fetch this cycle.
- ex_valid  out  1  EX output is a real instruction.
- ex_pc, ex_opResult, ex_memData, ex_branchDst  out  WIDTH.
- ex_memWE, ex_rfWE  out  1  gated by ex_valid.
- ex_rfDst  out  5;  ex_rfSrc  out  RF_SRC_W.
- ex_branchPermit  out  1.
- ex_hi, ex_lo  out  WIDTH  architectural HI/LO.

Behaviour:
- Reset (rst=0, async): all EX registers, HI, LO and FSM go to 0/IDLE. All outputs read 0, including ex_stall, ex_valid and ex_branchPermit. A reset during an MDU op aborts it; HI/LO stay 0.
- Pipeline register:
  - On a clk edge with ex_stall=0, it loads all id_* fields.
  - With ex_stall=1, it holds.
  - id_valid=0 loads a bubble: valid=0, rfWE=0, memWE=0.
- ALU (combinational from registered fields; shift amount = opa[log2(WIDTH)-1:0]):
  - 0 add, 1 sub, 2 and, 3 or, 4 sll (opb<<sa), 5 srl, 6 sra, 7 xor, 8 nor.
  - 9 slt (signed, result 1/0), 10 sltu.
  - 11 mult, 12 multu, 13 div, 14 divu: result 0, write HI/LO only.
  - 15 mfhi → HI, 16 mflo → LO.
  - Any other code → 0.
  - Arithmetic wraps modulo 2^WIDTH; no overflow traps.
- MDU FSM, states IDLE and RUN, with a log2(WIDTH)+1-bit counter:
  - IDLE→RUN on an edge that loads a valid op 11–14. Operands are captured from id_opa/id_opb and count is set to WIDTH-1.
  - RUN: one radix-2 iteration per edge (shift-add multiply, restoring divide on magnitudes). At count==0 the next edge writes HI/LO and returns to IDLE.
  - ex_stall = (state==RUN). ex_valid = 0 while RUN. The cycle after RUN, ex_valid=1 and the next instruction loads on the following edge. Total EX occupancy is WIDTH+1 cycles.
  - mult/multu: {HI,LO} = full 2·WIDTH product. Signed ops use magnitudes and fix the sign at the end.
  - div/divu: LO = quotient, HI = remainder. The remainder takes the dividend's sign and the quotient truncates toward zero.
  - Divide by zero: LO = all ones, HI = dividend; normal latency.
  - INT_MIN/−1: LO = INT_MIN, HI = 0.
  - mfhi/mflo immediately after an MDU op sees the updated HI/LO, because of the stall.
- Branch: uses the registered branch type and zero = ~|ex_opResult.
  - type 000 none, 001 → zero, 010 → ~zero, 011 → ex_opResult[WIDTH-1]; others → 0.
  - The result is ANDed with ex_valid.

Test Plan:
- Reset mid-multiply: issue mult 7×6, drop rst at iteration 10 → ex_stall=0, HI=LO=0, ex_valid=0 immediately.
- ALU sweep, WIDTH=32: sra(4, 0x80000000) → 0xF8000000; slt(−1, 1) → 1; sltu(0xFFFFFFFF, 1) → 0; nor(0, 0) → 0xFFFFFFFF.
- mult −3×5 then mflo/mfhi → ex_stall high exactly 32 cycles; then LO=0xFFFFFFF1 and HI=0xFFFFFFFF. mflo enters EX on the next edge after stall drops.
- div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 9/0 → LO=0xFFFFFFFF, HI=9. div 0x80000000/−1 → LO=0x80000000, HI=0.
- Branch: sub 5−5 with type 001 → ex_branchPermit=1. Same op with id_valid=0 → 0. Type 011 on slt-style negative result → 1.
- Stall hold: change all id_* fields during RUN → ex_rfDst/ex_memData unchanged, ex_memWE=ex_rfWE=0 until the stall releases.
